// File: rtl/mbv_result_collector.sv
// mbv_result_collector
// Reassembles U-element result beats from the tridiagonal matrix-by-vector
// engine into one MSB-first vector of N elements. Padding elements of the
// final beat are dropped. The vector is held with done=1 until start drops.
//
// Handshake: in_valid qualifies in_data for exactly one cycle. There is no
// ready signal because the block accepts a beat on every cycle it is in
// COLLECT. Beats in IDLE are ignored. Beats in DONE are ignored and set the
// sticky overflow flag.
module mbv_result_collector #(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width         = 32,
  parameter int no_of_units           = 4,
  parameter int no_of_beats           = (no_of_eqn_per_cluster + no_of_units - 1) / no_of_units
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       in_valid,
  input  logic [no_of_units*element_width-1:0]           in_data,
  output logic [no_of_eqn_per_cluster*element_width-1:0] out_vector,
  output logic                                       done,
  output logic                                       busy,
  output logic                                       overflow,
  output logic [1:0]                                 state_dbg
);

  localparam int N  = no_of_eqn_per_cluster;
  localparam int EW = element_width;
  localparam int U  = no_of_units;
  localparam int B  = no_of_beats;
  localparam int CW = $clog2(B) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   beat_cnt;
  logic            clear_vec;
  logic            write_beat;
  logic            clear_cnt;
  logic            set_ovf;
  logic            last_beat;

  assign last_beat = (beat_cnt == CW'(B - 1));

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode. start outranks in_valid, so an
  // abort coinciding with a beat never writes that beat.
  always_comb begin
    state_next = state;
    clear_vec  = 1'b0;
    write_beat = 1'b0;
    clear_cnt  = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_COLLECT;
          clear_vec  = 1'b1;
          clear_cnt  = 1'b1;
        end
      end
      S_COLLECT: begin
        if (!start) begin
          state_next = S_IDLE;
          clear_cnt  = 1'b1;
        end else if (in_valid) begin
          write_beat = 1'b1;
          if (last_beat) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_next = S_IDLE;
          clear_cnt  = 1'b1;
        end else if (in_valid) begin
          set_ovf = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        clear_cnt  = 1'b1;
      end
    endcase
  end

  // Beat counter: cleared on COLLECT entry and on abort, bumped per beat.
  always_ff @(posedge clk) begin
    if (reset || clear_cnt) begin
      beat_cnt <= '0;
    end else if (write_beat) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
  end

  // Vector assembly: equation k comes from element k%U of beat k/U. Equations
  // never addressed by a beat index are padding positions and do not exist,
  // so padding in the last beat simply has no destination.
  always_ff @(posedge clk) begin
    if (reset || clear_vec) begin
      out_vector <= '0;
    end else if (write_beat) begin
      for (int k = 0; k < N; k++) begin
        if (int'(beat_cnt) == k / U) begin
          out_vector[EW*(N-k)-1 -: EW] <= in_data[EW*(U-(k%U))-1 -: EW];
        end
      end
    end
  end

  // Sticky overflow: only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (set_ovf) begin
      overflow <= 1'b1;
    end
  end

  assign done      = (state == S_DONE);
  assign busy      = (state == S_COLLECT);
  assign state_dbg = state;

endmodule

// File: tb/tb_mbv_result_collector.sv
// Directed bench for mbv_result_collector: a default instance (N=10, U=4)
// and an exact-multiple instance (N=8, U=4) driven from one linear sequence.
module tb_mbv_result_collector;

  localparam int EW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // default instance
  logic           start, in_valid;
  logic [127:0]   in_data;
  logic [319:0]   out_vector;
  logic           done, busy, overflow;
  logic [1:0]     state_dbg;

  // exact-multiple instance
  logic           start2, in_valid2;
  logic [127:0]   in_data2;
  logic [255:0]   out_vector2;
  logic           done2, busy2, overflow2;
  logic [1:0]     state_dbg2;

  int errors = 0;
  int checks = 0;

  logic [319:0] exp_nom, exp_part, exp_new, exp_eight;

  mbv_result_collector #(.no_of_eqn_per_cluster(10), .element_width(EW), .no_of_units(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_vector(out_vector), .done(done), .busy(busy), .overflow(overflow), .state_dbg(state_dbg)
  );

  mbv_result_collector #(.no_of_eqn_per_cluster(8), .element_width(EW), .no_of_units(4)) dut8 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .out_vector(out_vector2), .done(done2), .busy(busy2), .overflow(overflow2), .state_dbg(state_dbg2)
  );

  // driver: advance one active edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3);
    in_valid = 1'b1;
    in_data  = {e0, e1, e2, e3};
    step();
    in_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    exp_nom   = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};
    exp_part  = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h0, 32'h0};
    exp_new   = {32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'h19, 32'h1A};
    exp_eight = {64'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    step(); step();
    reset = 1'b0;

    // reset state
    check("rst_vec",   out_vector, '0);
    check("rst_done",  320'(done), 320'(0));
    check("rst_busy",  320'(busy), 320'(0));
    check("rst_ovf",   320'(overflow), 320'(0));
    check("rst_state", 320'(state_dbg), 320'(0));

    // exact multiple: in_valid in entry cycle is ignored
    start2 = 1'b1; in_valid2 = 1'b1; in_data2 = {4{32'h77}};
    step();
    check("n8_entry_busy", 320'(busy2), 320'(1));
    check("n8_entry_vec",  320'(out_vector2), '0);
    in_data2 = {32'h1, 32'h2, 32'h3, 32'h4};
    step();
    check("n8_done_early", 320'(done2), 320'(0));
    in_data2 = {32'h5, 32'h6, 32'h7, 32'h8};
    step();
    in_valid2 = 1'b0;
    check("n8_done", 320'(done2), 320'(1));
    check("n8_vec",  320'(out_vector2), exp_eight);
    start2 = 1'b0;
    step();
    check("n8_idle", 320'(state_dbg2), 320'(0));

    // nominal: back-to-back beats
    start = 1'b1;
    step();
    check("nom_busy_entry", 320'(busy), 320'(1));
    beat(32'h1, 32'h2, 32'h3, 32'h4);
    beat(32'h5, 32'h6, 32'h7, 32'h8);
    check("nom_done_early", 320'(done), 320'(0));
    beat(32'h9, 32'hA, 32'hDEAD, 32'hBEEF);
    check("nom_done", 320'(done), 320'(1));
    check("nom_busy", 320'(busy), 320'(0));
    check("nom_vec",  out_vector, exp_nom);

    // overflow while done
    beat(32'hFF, 32'hFF, 32'hFF, 32'hFF);
    check("ovf_set",  320'(overflow), 320'(1));
    check("ovf_vec",  out_vector, exp_nom);
    check("ovf_done", 320'(done), 320'(1));
    step();
    check("ovf_sticky", 320'(overflow), 320'(1));

    // release start: vector and overflow held in IDLE
    start = 1'b0;
    step();
    check("rel_done",  320'(done), 320'(0));
    check("rel_state", 320'(state_dbg), 320'(0));
    check("rel_vec",   out_vector, exp_nom);
    check("rel_ovf",   320'(overflow), 320'(1));

    // gapped beats
    start = 1'b1;
    step();
    check("gap_entry_vec", out_vector, '0);
    check("gap_entry_ovf", 320'(overflow), 320'(1));
    beat(32'h1, 32'h2, 32'h3, 32'h4);
    step(); step();
    beat(32'h5, 32'h6, 32'h7, 32'h8);
    step(); step();
    check("gap_done_early", 320'(done), 320'(0));
    check("gap_busy", 320'(busy), 320'(1));
    beat(32'h9, 32'hA, 32'hDEAD, 32'hBEEF);
    check("gap_done", 320'(done), 320'(1));
    check("gap_vec",  out_vector, exp_nom);

    // abort mid-vector; abort coinciding with a beat drops the beat
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    beat(32'h1, 32'h2, 32'h3, 32'h4);
    beat(32'h5, 32'h6, 32'h7, 32'h8);
    start = 1'b0;
    beat(32'h9, 32'hA, 32'hDEAD, 32'hBEEF);
    check("abort_state", 320'(state_dbg), 320'(0));
    check("abort_done",  320'(done), 320'(0));
    check("abort_vec",   out_vector, exp_part);
    start = 1'b1;
    step();
    check("restart_vec0", out_vector, '0);
    beat(32'h11, 32'h12, 32'h13, 32'h14);
    beat(32'h15, 32'h16, 32'h17, 32'h18);
    beat(32'h19, 32'h1A, 32'hDEAD, 32'hBEEF);
    check("restart_done", 320'(done), 320'(1));
    check("restart_vec",  out_vector, exp_new);

    // reset mid-COLLECT after beat0
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    beat(32'h1, 32'h2, 32'h3, 32'h4);
    reset = 1'b1;
    beat(32'h5, 32'h6, 32'h7, 32'h8);
    reset = 1'b0;
    check("mrst_vec",   out_vector, '0);
    check("mrst_done",  320'(done), 320'(0));
    check("mrst_busy",  320'(busy), 320'(0));
    check("mrst_ovf",   320'(overflow), 320'(0));
    check("mrst_state", 320'(state_dbg), 320'(0));
    step();
    check("mrst_entry_busy", 320'(busy), 320'(1));
    beat(32'h1, 32'h2, 32'h3, 32'h4);
    beat(32'h5, 32'h6, 32'h7, 32'h8);
    beat(32'h9, 32'hA, 32'hDEAD, 32'hBEEF);
    check("mrst_run_done", 320'(done), 320'(1));
    check("mrst_run_vec",  out_vector, exp_nom);
    check("mrst_run_ovf",  320'(overflow), 320'(0));

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mbv_result_collector.md
# mbv_result_collector

Receive-side counterpart of the streaming tridiagonal matrix-by-vector engine. The engine emits results as beats of `no_of_units` elements. This block accepts those beats and reassembles them into one full, MSB-first result vector of `no_of_eqn_per_cluster` elements. Padding elements in the final beat are discarded, completion is signalled with `done`, and the vector is held until the controller drops `start`. It sits between the multiplier engine and the per-cluster solver update logic.

## Interface
- `no_of_eqn_per_cluster`, 10, number of result elements (N).
- `element_width`, 32, bits per element (EW).
- `no_of_units`, 4, elements per incoming beat (U).
- `no_of_beats`, derived as ceil(N/U), beats per vector (B); 3 at defaults.
- `clk` input 1: clock, rising-edge.
- `reset` input 1: reset, synchronous, active-high; clock clk.
- `start` input 1: run enable, same semantics as the engine's `start`. High means run; low means abort and clear.
- `in_valid` input 1: `in_data` carries a result beat this cycle.
- `in_data` input U*EW: beat payload. Element j of the beat sits at `[EW*(U-j)-1 -: EW]`.
- `out_vector` output N*EW: assembled result. Equation k sits at `[EW*(N-k)-1 -: EW]`.
- `done` output 1: `out_vector` is complete and stable.
- `busy` output 1: high in COLLECT.
- `overflow` output 1: sticky; a beat arrived while in DONE.

## Operation
- States: IDLE, COLLECT, DONE. Internal `beat_cnt` has width clog2(B)+1.
- Reset (any state, any cycle) forces:
  - state to IDLE;
  - `beat_cnt` to 0;
  - `out_vector` to 0;
  - `done`, `busy` and `overflow` to 0.
- IDLE:
  - `start`=1 moves to COLLECT next cycle. On entry, `beat_cnt`<=0 and `out_vector`<=0.
  - `in_valid` is ignored in IDLE, including the cycle in which `start` is first seen high.
- COLLECT, `in_valid`=1 with `start`=1:
  - Beat b=`beat_cnt` writes equation b*U+j from element j, for every j where b*U+j < N.
  - Elements with b*U+j >= N are padding and are dropped.
  - `beat_cnt` increments.
  - If b==B-1, go to DONE.
- COLLECT, `in_valid`=0: hold all state.
- DONE:
  - `done`=1 and `out_vector` is frozen.
  - `in_valid`=1 sets `overflow`; the data is ignored.
- `start`=0 in COLLECT or DONE:
  - go to IDLE next cycle;
  - `done`<=0 and `beat_cnt`<=0;
  - `out_vector` and `overflow` keep their values until the next COLLECT entry.
  - COLLECT entry clears `out_vector` only; `overflow` clears only on reset.
- Simultaneous `start`=0 and `in_valid`=1: the abort wins and the beat is not written.
- Reset has priority over `start`, and `start` has priority over `in_valid`.
- No arithmetic on data: bits are copied unchanged. Unwritten element slices stay 0.

## Timing
- Beat sampled on edge t: its elements are visible in `out_vector` after edge t.
- Last beat sampled on edge t: `done`=1 and the complete `out_vector` appear on the same cycle after edge t. Latency from last beat to `done` is 1 cycle.
- `busy` is high on the cycle after the `start` rise (edge t+1 with `start` seen at t). It goes low in the same cycle `done` rises.
- Minimum vector time is B+1 cycles from the first `start` sample to `done`: one entry cycle plus B back-to-back beats.
- Back-to-back beats are accepted every cycle. No backpressure: the block is always ready in COLLECT.
- A new vector requires `start` low for at least 1 cycle, then high again.

## Test plan
- Nominal (N=10, U=4), three back-to-back beats after entry:
  - beat0 elements 1,2,3,4;
  - beat1 elements 5,6,7,8;
  - beat2 elements 9,0xA,0xDEAD,0xBEEF.
  - Required: `out_vector` = elements 1..0xA in MSB-first order, with 0xDEAD and 0xBEEF absent.
  - Required: `done`=1 exactly 1 cycle after beat2 is sampled; `busy`=0 from then.
- Gapped beats: same data with 2 idle `in_valid`=0 cycles between beats. Required: identical `out_vector`; `done` rises 1 cycle after the third beat.
- Abort mid-vector:
  - `start` low after beat1: state returns to IDLE, `done` stays 0.
  - Restart with beats of 0x11..0x1A: result is exactly 0x11..0x1A, with no stale 1..8.
- Overflow: after `done`, drive an extra beat of 0xFF values. Required: `overflow`=1 sticky, `out_vector` unchanged.
- Reset mid-COLLECT after beat0: all outputs are 0 the next cycle; a following full run completes normally.
- Exact multiple (N=8, U=4, B=2): two beats fill all 8 elements, nothing is dropped, `done` follows 1 cycle after beat1; `in_valid` in the entry cycle is ignored.
